// File: rtl/jtag_uart_master.sv
// jtag_uart_master: byte stream <-> JTAG UART Avalon-MM slave; RX path built only with `define JTAG_UART_MASTER_RX_EN.
// Latency: one Avalon access per grant, ending on the first clk_clk edge that sees uart_waitrequest low.
// Backpressure: tx_ready low while the one-byte TX buffer is full; no RX read is issued while rx_valid is held.
module jtag_uart_master #(
  parameter int POLL_DIV = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        uart_chipselect,
  output logic        uart_address,
  output logic        uart_read_n,
  output logic        uart_write_n,
  output logic [31:0] uart_writedata,
  input  logic [31:0] uart_readdata,
  input  logic        uart_waitrequest,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TX_CTRL, TX_WRITE, RX_READ} state_t;

  typedef struct packed {
    logic        cs;
    logic        addr;
    logic        read_n;
    logic        write_n;
    logic [31:0] wdata;
  } av_cmd_t;

  localparam logic [15:0] POLL_RELOAD = 16'(POLL_DIV);

  state_t      state;
  av_cmd_t     av;
  logic [7:0]  tx_buf;
  logic [15:0] wspace;
  logic [15:0] retry_tmr;
  logic        prefer_rx;
  logic [15:0] rd_hi;
  logic        done;
  logic        tx_elig;
  logic        rx_elig;
  logic        grant_rx;
  logic        grant_tx;

  assign uart_chipselect = av.cs;
  assign uart_address    = av.addr;
  assign uart_read_n     = av.read_n;
  assign uart_write_n    = av.write_n;
  assign uart_writedata  = av.wdata;

  assign rd_hi    = uart_readdata[31:16];
  assign done     = (state != IDLE) && !uart_waitrequest;
  // A pending byte goes straight out on cached space, otherwise a control read refreshes the cache.
  assign tx_elig  = !tx_ready && ((wspace != 16'd0) || (retry_tmr == 16'd0));
  assign grant_rx = rx_elig && (!tx_elig || prefer_rx);
  assign grant_tx = tx_elig && !grant_rx;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= IDLE;
      av.cs      <= 1'b0;
      av.addr    <= 1'b0;
      av.read_n  <= 1'b1;
      av.write_n <= 1'b1;
      av.wdata   <= 32'h0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      tx_buf     <= 8'h0;
      wspace     <= 16'd0;
      retry_tmr  <= 16'd0;
      prefer_rx  <= 1'b0;
    end else begin
      if (retry_tmr != 16'd0) retry_tmr <= retry_tmr - 16'd1;
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (grant_rx) begin
            state     <= RX_READ;
            av.cs     <= 1'b1;
            av.addr   <= 1'b0;
            av.read_n <= 1'b0;
            busy      <= 1'b1;
            prefer_rx <= 1'b0;
          end else if (grant_tx) begin
            av.cs     <= 1'b1;
            busy      <= 1'b1;
            prefer_rx <= 1'b1;
            if (wspace != 16'd0) begin
              state      <= TX_WRITE;
              av.addr    <= 1'b0;
              av.write_n <= 1'b0;
              av.wdata   <= {24'h0, tx_buf};
            end else begin
              state     <= TX_CTRL;
              av.addr   <= 1'b1;
              av.read_n <= 1'b0;
            end
          end
        end
        default: begin
          if (done) begin
            state      <= IDLE;
            av.cs      <= 1'b0;
            av.read_n  <= 1'b1;
            av.write_n <= 1'b1;
            busy       <= 1'b0;
            if (state == TX_CTRL) begin
              wspace <= rd_hi;
              if (rd_hi == 16'd0) retry_tmr <= POLL_RELOAD;
            end
            if (state == TX_WRITE) begin
              tx_ready <= 1'b1;
              if (wspace != 16'd0) wspace <= wspace - 16'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef JTAG_UART_MASTER_RX_EN
  logic [15:0] poll_tmr;
  logic        rx_more;
  logic        unused_rd;

  assign unused_rd = ^uart_readdata[14:8];
  // Keep reading back-to-back while the UART reports more bytes queued.
  assign rx_elig   = !rx_valid && ((poll_tmr == 16'd0) || rx_more);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      poll_tmr <= 16'd0;
      rx_more  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h0;
    end else begin
      if (poll_tmr != 16'd0) poll_tmr <= poll_tmr - 16'd1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if ((state == RX_READ) && done) begin
        rx_more <= (rd_hi != 16'd0);
        if (uart_readdata[15]) begin
          rx_data  <= uart_readdata[7:0];
          rx_valid <= 1'b1;
        end else begin
          poll_tmr <= POLL_RELOAD;
        end
      end
    end
  end
`else
  logic unused_rx;

  assign unused_rx = ^{rx_ready, uart_readdata[15:0]};
  assign rx_elig   = 1'b0;
  assign rx_valid  = 1'b0;
  assign rx_data   = 8'h0;
`endif

endmodule

// File: tb/tb_jtag_uart_master.sv
// Directed bench for jtag_uart_master with a small Avalon slave model; RX scenario runs when JTAG_UART_MASTER_RX_EN is defined.
module tb_jtag_uart_master;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        uart_chipselect;
  logic        uart_address;
  logic        uart_read_n;
  logic        uart_write_n;
  logic [31:0] uart_writedata;
  logic [31:0] uart_readdata;
  logic        uart_waitrequest;
  logic        busy;

  logic [31:0] ctrl_rd;
  logic [31:0] data_rd;
  int          wr_stall;
  int          wr_seen = 0;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  int n_acc = 0, n_wr = 0, n_ctrl = 0, n_rd = 0, rx_hi_cnt = 0;
  int ctrl_cyc = 0, ctrl_cyc_prev = 0, rd_cyc = 0, rd_cyc_prev = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        last_waddr = 1'b1;

  jtag_uart_master #(.POLL_DIV(16)) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .uart_chipselect  (uart_chipselect),
    .uart_address     (uart_address),
    .uart_read_n      (uart_read_n),
    .uart_write_n     (uart_write_n),
    .uart_writedata   (uart_writedata),
    .uart_readdata    (uart_readdata),
    .uart_waitrequest (uart_waitrequest),
    .busy             (busy)
  );

  always #5 clk_clk = ~clk_clk;

  assign uart_readdata    = uart_address ? ctrl_rd : data_rd;
  assign uart_waitrequest = uart_chipselect && !uart_write_n && (wr_seen < wr_stall);

  always @(posedge clk_clk) begin
    cyc     <= cyc + 1;
    wr_seen <= (uart_chipselect && !uart_write_n) ? wr_seen + 1 : 0;
  end

  // Each access is logged once, in the cycle before the edge that completes it.
  always @(negedge clk_clk) begin
    if (uart_chipselect && !uart_waitrequest && !reset_reset) begin
      n_acc = n_acc + 1;
      if (!uart_write_n) begin
        n_wr       = n_wr + 1;
        last_wdata = uart_writedata;
        last_waddr = uart_address;
      end else if (uart_address) begin
        n_ctrl        = n_ctrl + 1;
        ctrl_cyc_prev = ctrl_cyc;
        ctrl_cyc      = cyc;
      end else begin
        n_rd        = n_rd + 1;
        rd_cyc_prev = rd_cyc;
        rd_cyc      = cyc;
      end
    end
    if (rx_valid) rx_hi_cnt = rx_hi_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    for (int i = 0; i < 200 && !tx_ready; i++) tick();
    chk("send_ready", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  int c0, w0, r0, a0, v0, k;

  initial begin
    tx_data  = 8'h0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    ctrl_rd  = 32'h0;
    data_rd  = 32'h0;
    wr_stall = 0;

    // Reset values
    smp();
    chk("rst_cs", uart_chipselect, 0);
    chk("rst_read_n", uart_read_n, 1);
    chk("rst_write_n", uart_write_n, 1);
    chk("rst_addr", uart_address, 0);
    chk("rst_wdata", uart_writedata, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset_reset = 1'b0;

    // Basic TX: one control read, then writes from the cache
    ctrl_rd = 32'h0040_0000;
    send(8'h41);
    for (int i = 0; i < 50 && n_wr < 1; i++) smp();
    chk("tx1_writes", n_wr, 1);
    chk("tx1_ctrl", n_ctrl, 1);
    chk("tx1_wdata", last_wdata, 32'h0000_0041);
    chk("tx1_waddr", last_waddr, 0);
    send(8'h42);
    for (int i = 0; i < 50 && n_wr < 2; i++) smp();
    chk("tx2_writes", n_wr, 2);
    chk("tx2_ctrl", n_ctrl, 1);
    chk("tx2_wdata", last_wdata, 32'h0000_0042);
    smp();
    chk("tx2_wspace", dut.wspace, 62);

    // Write stalled by waitrequest for 3 cycles
    wr_stall = 3;
    w0 = n_wr;
    send(8'h43);
    for (int i = 0; i < 50 && !(uart_chipselect && !uart_write_n); i++) smp();
    for (int j = 0; j < 4; j++) begin
      chk("stall_hold", {uart_chipselect, uart_address, uart_read_n, uart_write_n, busy, tx_ready, uart_writedata},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0043});
      smp();
    end
    chk("stall_end_cs", uart_chipselect, 0);
    chk("stall_end_tx_ready", tx_ready, 1);
    chk("stall_writes", n_wr - w0, 1);
    wr_stall = 0;

    // Reset asserted while a write is stalled
    wr_stall = 1000;
    w0 = n_wr;
    c0 = n_ctrl;
    send(8'h45);
    for (int i = 0; i < 50 && !(uart_chipselect && !uart_write_n); i++) smp();
    chk("rstw_in_write", uart_chipselect && !uart_write_n, 1);
    smp();
    reset_reset = 1'b1;
    #1;
    chk("rstw_cs", uart_chipselect, 0);
    chk("rstw_write_n", uart_write_n, 1);
    chk("rstw_tx_ready", tx_ready, 1);
    chk("rstw_busy", busy, 0);
    wr_stall = 0;
    tick();
    tick();
    reset_reset = 1'b0;
    repeat (30) tick();
    chk("rstw_no_write", n_wr - w0, 0);
    chk("rstw_no_ctrl", n_ctrl - c0, 0);
    chk("rstw_wspace", dut.wspace, 0);

    // No space reported: retry only after the timer, then exactly one write
    ctrl_rd = 32'h0;
    c0 = n_ctrl;
    w0 = n_wr;
    send(8'h44);
    for (int i = 0; i < 50 && n_ctrl < c0 + 1; i++) smp();
    chk("nosp_ctrl1", n_ctrl - c0, 1);
    smp();
    ctrl_rd = 32'h0001_0000;
    for (int i = 0; i < 60 && n_ctrl < c0 + 2; i++) smp();
    chk("nosp_ctrl2", n_ctrl - c0, 2);
    chk("nosp_no_early_write", n_wr - w0, 0);
    chk("nosp_gap_min", (ctrl_cyc - ctrl_cyc_prev) >= 16, 1);
    chk("nosp_gap_max", (ctrl_cyc - ctrl_cyc_prev) <= 22, 1);
    for (int i = 0; i < 50 && n_wr < w0 + 1; i++) smp();
    repeat (40) smp();
    chk("nosp_one_write", n_wr - w0, 1);
    chk("nosp_ctrl_total", n_ctrl - c0, 2);
    chk("nosp_wdata", last_wdata, 32'h0000_0044);

`ifdef JTAG_UART_MASTER_RX_EN
    // RX with back-pressure and RAVAIL-driven immediate re-read
    data_rd  = 32'h0002_8055;
    rx_ready = 1'b0;
    for (int i = 0; i < 100 && !rx_valid; i++) smp();
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data", rx_data, 8'h55);
    data_rd = 32'h0;
    r0 = n_rd;
    repeat (10) smp();
    chk("rx_bp_no_reads", n_rd - r0, 0);
    chk("rx_bp_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && n_rd == r0; i++) begin
      smp();
      k++;
    end
    chk("rx_immediate_read", k <= 2, 1);
    v0 = rx_hi_cnt;
    for (int i = 0; i < 60 && n_rd < r0 + 2; i++) smp();
    chk("rx_poll_reads", n_rd - r0, 2);
    chk("rx_stays_low", rx_hi_cnt - v0, 0);
    chk("rx_poll_gap_min", (rd_cyc - rd_cyc_prev) >= 16, 1);
    chk("rx_poll_gap_max", (rd_cyc - rd_cyc_prev) <= 20, 1);
`else
    // RX compiled out: an idle TX side means a silent bus
    a0 = n_acc;
    v0 = rx_hi_cnt;
    rx_ready = 1'b1;
    repeat (1000) smp();
    chk("idle_no_access", n_acc - a0, 0);
    chk("idle_rx_valid", rx_hi_cnt - v0, 0);
    chk("idle_rx_data", rx_data, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_uart_master.md
JTAG_UART_MASTER -- requirements
Module: jtag_uart_master

Interface
REQ-001 SHALL have parameter POLL_DIV, default 16: idle cycles between RX polls and between zero-WSPACE retries (legal range 1..65535).
REQ-002 SHALL have ports: clk_clk in 1, clock; reset_reset in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: tx_data in 8, byte to send; tx_valid in 1; tx_ready out 1.
REQ-004 SHALL have ports: rx_data out 8, received byte; rx_valid out 1; rx_ready in 1.
REQ-005 SHALL have Avalon master ports: uart_chipselect out 1; uart_address out 1 (0=data, 1=control); uart_read_n out 1; uart_write_n out 1; uart_writedata out 32; uart_readdata in 32; uart_waitrequest in 1.
REQ-006 SHALL have port busy out 1: high while any Avalon access is in progress.

Function
REQ-007 SHALL implement FSM states IDLE, TX_CTRL (read address 1), TX_WRITE (write address 0), RX_READ (read address 0); all outputs registered.
REQ-008 In each access state, chipselect, address, read_n/write_n and writedata SHALL be held stable; the access completes on the first rising edge with uart_waitrequest=0, with readdata sampled at that edge; FSM returns to IDLE on the same edge.
REQ-009 TX: one-byte buffer; tx_ready = buffer empty; byte captured on tx_valid&&tx_ready; buffer cleared at TX_WRITE completion, so tx_ready rises the next cycle.
REQ-010 SHALL keep a 16-bit WSPACE cache (reset 0): loaded from uart_readdata[31:16] at TX_CTRL completion, decremented at each TX_WRITE completion.
REQ-011 From IDLE with a TX byte pending: cache>0 -> TX_WRITE with writedata = {24'h0, byte}; cache=0 and retry timer expired -> TX_CTRL.
REQ-012 If TX_CTRL loads WSPACE=0, the retry timer SHALL reload POLL_DIV, and TX_CTRL is not re-entered before it expires.
REQ-013 RX: RX_READ is eligible only when rx_valid=0 and either the poll timer has expired or the previous read reported RAVAIL (readdata[31:16]) nonzero.
REQ-014 At RX_READ completion with readdata[15] (RVALID)=1: rx_data <= readdata[7:0], rx_valid <= 1; with RVALID=0: no change, poll timer reloads POLL_DIV.
REQ-015 rx_valid SHALL clear on rx_valid&&rx_ready; no RX byte is ever dropped or overwritten.
REQ-016 When TX and RX are both eligible in IDLE, grant SHALL alternate (last-grant bit, reset favours TX).
REQ-017 Timers SHALL count down one per cycle while nonzero, saturating at 0.

Reset
REQ-018 On reset_reset=1, immediately (asynchronously): state IDLE, uart_chipselect 0, uart_read_n 1, uart_write_n 1, uart_address 0, uart_writedata 0, tx_ready 1, rx_valid 0, rx_data 0, busy 0, WSPACE cache 0, timers 0, TX buffer empty.
REQ-019 Reset asserted mid-access SHALL abandon the access and discard the pending TX byte; operation resumes from IDLE on the first edge after deassertion.

Configuration
REQ-020 With macro JTAG_UART_MASTER_RX_EN defined, the RX path (REQ-013..REQ-015) SHALL be compiled in.
REQ-021 Without JTAG_UART_MASTER_RX_EN, RX_READ SHALL never be entered, rx_valid and rx_data tied to 0, rx_ready ignored, and TX always granted.

Verification
REQ-022 TX basic: send 0x41, control read returns 0x0040_0000 -> one TX_CTRL, then write addr 0 writedata 0x0000_0041; next byte 0x42 written with no control read; cache ends at 62.
REQ-023 Stall: waitrequest held high 3 cycles during TX_WRITE -> all master outputs stable for 4 cycles, tx_ready low until the cycle after completion.
REQ-024 No space: control read returns 0x0000_0000, POLL_DIV=16 -> no write, next TX_CTRL not before 16 cycles; retry returns 0x0001_0000 -> exactly one write.
REQ-025 RX back-pressure (macro defined): data read returns 0x0002_8055 -> rx_data 0x55, rx_valid 1; rx_ready held low 10 cycles -> no reads issued; after handshake, immediate RX_READ without timer wait; read returning 0x0000_0000 -> rx_valid stays 0, next poll after 16 cycles.
REQ-026 Reset mid-write: reset asserted while TX_WRITE stalled by waitrequest -> chipselect 0, write_n 1, tx_ready 1 without a clock edge.
REQ-027 Macro undefined: 1000 cycles with TX idle -> zero Avalon accesses, rx_valid constant 0.
